// File: rtl/ysyx_issue_scoreboard_if.sv
// IDU -> scoreboard -> EXU handshake, writeback and flush signals for ysyx_issue_scoreboard.
interface ysyx_issue_scoreboard_if #(
   parameter int IF_W = 3
);
   logic            idu_valid;
   logic            idu_ready_o;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            use_rs1;
   logic            use_rs2;
   logic [4:0]      rd;
   logic            rwen;
   logic            exu_valid_o;
   logic            exu_ready;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic            flush;
   logic            stall_o;
   logic [IF_W-1:0] inflight_o;

   modport master (
      output idu_valid, rs1, rs2, use_rs1, use_rs2, rd, rwen, exu_ready,
             wb_valid, wb_rd, flush,
      input  idu_ready_o, exu_valid_o, stall_o, inflight_o
   );

   modport slave (
      input  idu_valid, rs1, rs2, use_rs1, use_rs2, rd, rwen, exu_ready,
             wb_valid, wb_rd, flush,
      output idu_ready_o, exu_valid_o, stall_o, inflight_o
   );
endinterface

// File: rtl/ysyx_issue_scoreboard.sv
// RAW-hazard issue scoreboard between IDU and EXU.
// Define YSYX_SB_WB_BYPASS_EN to let a dependent issue in the same cycle as its writeback.
module ysyx_issue_scoreboard #(
   parameter int NR_REG       = 32,
   parameter int CNT_W        = 2,
   parameter int MAX_INFLIGHT = 4,
   parameter int IF_W         = 3
) (
   input logic                   clk,
   input logic                   rst,
   ysyx_issue_scoreboard_if.slave sb
);
   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [IF_W-1:0]  IF_MAX  = IF_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0] cnt [NR_REG];
   logic [IF_W-1:0]  inflight;
   state_t           state;

   logic busy_rs1, busy_rs2, rd_sat, hazard, full, block;
   logic fire, inc_en, dec_en, if_dec;

   function automatic logic reg_busy(input logic [4:0] r);
      logic b;
      b = (r != 5'd0) && (cnt[r] != '0);
`ifdef YSYX_SB_WB_BYPASS_EN
      // last outstanding write retiring this cycle: regfile forwards the data
      if (sb.wb_valid && (sb.wb_rd == r) && (cnt[r] == CNT_W'(1))) b = 1'b0;
`endif
      return b;
   endfunction

   always_comb begin
      busy_rs1       = reg_busy(sb.rs1);
      busy_rs2       = reg_busy(sb.rs2);
      rd_sat         = sb.rwen && (sb.rd != 5'd0) && (cnt[sb.rd] == CNT_MAX);
      hazard         = (sb.use_rs1 && busy_rs1) || (sb.use_rs2 && busy_rs2) || rd_sat;
      full           = (inflight == IF_MAX);
      block          = hazard || full || sb.flush;
      sb.exu_valid_o = sb.idu_valid && !block;
      sb.idu_ready_o = sb.exu_ready && !block;
      sb.stall_o     = sb.idu_valid && block && !sb.flush;
      fire           = sb.idu_valid && !block && sb.exu_ready;
      inc_en         = fire && sb.rwen && (sb.rd != 5'd0);
      // a writeback against an empty counter is stale (issued before a flush)
      dec_en         = sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt[sb.wb_rd] != '0);
      if_dec         = sb.wb_valid && (inflight != '0);
   end

   assign sb.inflight_o = inflight;

   always_ff @(posedge clk) begin
      if (rst || sb.flush) begin
         for (int unsigned r = 0; r < NR_REG; r++) cnt[r] <= '0;
         inflight <= '0;
         state    <= rst ? RUN : FLUSH;
      end else begin
         // fire and writeback on the same register cancel out
         if (inc_en && !(dec_en && (sb.wb_rd == sb.rd)))
            cnt[sb.rd] <= cnt[sb.rd] + 1'b1;
         if (dec_en && !(inc_en && (sb.wb_rd == sb.rd)))
            cnt[sb.wb_rd] <= cnt[sb.wb_rd] - 1'b1;
         inflight <= inflight + IF_W'(fire) - IF_W'(if_dec);
         case (state)
            RUN:     if (sb.idu_valid && (hazard || full)) state <= STALL;
            STALL:   if (!sb.idu_valid || !(hazard || full)) state <= RUN;
            FLUSH:   state <= RUN;
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_issue_scoreboard.sv
// Self-checking bench for ysyx_issue_scoreboard: directed literal scenarios plus randomized
// traffic compared every cycle against a counter-array reference model.
module tb_ysyx_issue_scoreboard;
   localparam int IF_W  = 3;
   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;
   localparam int MAXIF = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ysyx_issue_scoreboard_if #(.IF_W(IF_W)) sb ();

   ysyx_issue_scoreboard #(
      .NR_REG(32), .CNT_W(CNT_W), .MAX_INFLIGHT(MAXIF), .IF_W(IF_W)
   ) dut (
      .clk(clk), .rst(rst), .sb(sb)
   );

   int errors = 0;
   int checks = 0;
   int m_cnt [32];
   int m_infl;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(input int r);
      if (r == 0 || m_cnt[r] == 0) return 1'b0;
`ifdef YSYX_SB_WB_BYPASS_EN
      if (sb.wb_valid && int'(sb.wb_rd) == r && m_cnt[r] == 1) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic void m_eval(output bit ev, output bit ir, output bit st);
      bit haz, blk;
      haz = (sb.use_rs1 && m_busy(int'(sb.rs1))) || (sb.use_rs2 && m_busy(int'(sb.rs2)))
            || (sb.rwen && sb.rd != 5'd0 && m_cnt[sb.rd] == MAXC);
      blk = haz || (m_infl == MAXIF) || sb.flush;
      ev  = sb.idu_valid && !blk;
      ir  = sb.exu_ready && !blk;
      st  = sb.idu_valid && blk && !sb.flush;
   endfunction

   // reference model state advance
   always @(posedge clk) begin
      bit ev, ir, st, fire, wbdec;
      int old;
      if (rst || sb.flush) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_infl = 0;
      end else begin
         m_eval(ev, ir, st);
         fire  = ev && sb.exu_ready;
         wbdec = sb.wb_valid && sb.wb_rd != 5'd0 && m_cnt[sb.wb_rd] > 0;
         if (wbdec) m_cnt[sb.wb_rd] = m_cnt[sb.wb_rd] - 1;
         if (fire && sb.rwen && sb.rd != 5'd0) m_cnt[sb.rd] = m_cnt[sb.rd] + 1;
         old    = m_infl;
         m_infl = old + (fire ? 1 : 0) - ((sb.wb_valid && old > 0) ? 1 : 0);
      end
   end

   // compare process
   always @(negedge clk) begin
      bit ev, ir, st;
      if (!rst) begin
         m_eval(ev, ir, st);
         check("exu_valid_o", sb.exu_valid_o, ev);
         check("idu_ready_o", sb.idu_ready_o, ir);
         check("stall_o",     sb.stall_o,     st);
         check("inflight_o",  sb.inflight_o,  m_infl);
      end
   end

   task automatic drive(input bit iv, input int r1, input bit u1, input int r2, input bit u2,
                        input int d, input bit rw, input bit er, input bit wv, input int wr,
                        input bit fl);
      sb.idu_valid = iv;  sb.rs1 = 5'(r1); sb.use_rs1 = u1;
      sb.rs2 = 5'(r2);    sb.use_rs2 = u2;
      sb.rd = 5'(d);      sb.rwen = rw;    sb.exu_ready = er;
      sb.wb_valid = wv;   sb.wb_rd = 5'(wr); sb.flush = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      repeat (2) tick();
      rst = 1'b0;
      #2;
      check("rst_exu_valid", sb.exu_valid_o, 0);
      check("rst_idu_ready", sb.idu_ready_o, 1);
      check("rst_stall",     sb.stall_o,     0);
      check("rst_inflight",  sb.inflight_o,  0);
      tick(); drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0); #2;
      check("first_issue", sb.exu_valid_o, 1);
      check("first_infl",  sb.inflight_o,  0);

      // RAW on x5
      do_flush();
      tick(); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); #2;
      check("raw_producer", sb.exu_valid_o, 1);
      tick(); drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0); #2;
      check("raw_stall", sb.stall_o, 1);
      check("raw_hold",  sb.exu_valid_o, 0);
      tick(); drive(1, 5, 1, 0, 0, 0, 0, 1, 1, 5, 0); #2;
`ifdef YSYX_SB_WB_BYPASS_EN
      check("raw_wb_bypass_issue", sb.exu_valid_o, 1);
      check("raw_wb_bypass_stall", sb.stall_o, 0);
`else
      check("raw_wb_cycle_stall", sb.stall_o, 1);
      check("raw_wb_cycle_hold",  sb.exu_valid_o, 0);
`endif
      tick(); drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0); #2;
      check("raw_after_wb_issue", sb.exu_valid_o, 1);
`ifdef YSYX_SB_WB_BYPASS_EN
      check("raw_after_wb_infl", sb.inflight_o, 1);
`else
      check("raw_after_wb_infl", sb.inflight_o, 0);
`endif

      // in-flight window full, all writes to x0
      do_flush();
      for (int i = 0; i < 4; i++) begin
         tick(); drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0); #2;
         check("win_issue", sb.exu_valid_o, 1);
         check("win_infl",  sb.inflight_o, 32'(i));
      end
      tick(); drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0); #2;
      check("win_full_infl",  sb.inflight_o, 4);
      check("win_full_stall", sb.stall_o, 1);
      check("win_full_ready", sb.idu_ready_o, 0);
      tick(); drive(1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0); #2;
      check("win_wb_cycle_stall", sb.stall_o, 1);
      tick(); drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0); #2;
      check("win_after_wb_infl",  sb.inflight_o, 3);
      check("win_after_wb_issue", sb.exu_valid_o, 1);

      // WAW saturation on x7
      do_flush();
      for (int i = 0; i < 3; i++) begin
         tick(); drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); #2;
         check("waw_issue", sb.exu_valid_o, 1);
      end
      tick(); drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); #2;
      check("waw_sat_stall", sb.stall_o, 1);
      check("waw_sat_infl",  sb.inflight_o, 3);
      tick(); drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0); #2;
      check("waw_wb_cycle_stall", sb.stall_o, 1);
      tick(); drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); #2;
      check("waw_release_issue", sb.exu_valid_o, 1);
      check("waw_release_infl",  sb.inflight_o, 2);

      // flush with pending x9 writes, then a stale writeback
      do_flush();
      tick(); drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
      tick(); drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
      tick(); drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick(); drive(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 1); #2;
      check("flush_exu_valid", sb.exu_valid_o, 0);
      check("flush_idu_ready", sb.idu_ready_o, 0);
      check("flush_stall",     sb.stall_o, 0);
      check("flush_infl",      sb.inflight_o, 3);
      tick(); drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0); #2;
      check("post_flush_issue", sb.exu_valid_o, 1);
      check("post_flush_infl",  sb.inflight_o, 0);
      tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0);
      tick(); drive(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0); #2;
      check("stale_wb_infl",  sb.inflight_o, 0);
      check("stale_wb_issue", sb.exu_valid_o, 1);

      // same-cycle fire and writeback on x3
      do_flush();
      tick(); drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0); #2;
      check("same_first_issue", sb.exu_valid_o, 1);
      tick(); drive(1, 0, 0, 0, 0, 3, 1, 1, 1, 3, 0); #2;
      check("same_fire_wb_issue", sb.exu_valid_o, 1);
      check("same_fire_wb_infl",  sb.inflight_o, 1);
      tick(); drive(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0); #2;
      check("same_cnt_kept_stall", sb.stall_o, 1);
      check("same_infl_kept",      sb.inflight_o, 1);

      // randomized traffic on a small register set to provoke hazards
      do_flush();
      for (int n = 0; n < 3000; n++) begin
         tick();
         drive($urandom_range(0, 3) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
               $urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 199) == 0);
      end
      tick(); rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
